// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control signal bundle: ID/EX/MEM stage status in, stage enables/flushes out.
// master drives the stage status; slave is the hazard controller.
interface hazard_ctrl_if;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic        ex_reg_write;
    logic [2:0]  ex_write_reg;
    logic        mem_req;
    logic        mem_done;
    logic        mem_branch_taken;
    logic        mem_halt;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        mem_wb_flush;
    logic        halted;
    logic [15:0] stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write,
               ex_write_reg, mem_req, mem_done, mem_branch_taken, mem_halt,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
               id_ex_flush, ex_mem_flush, mem_wb_flush, halted, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write,
               ex_write_reg, mem_req, mem_done, mem_branch_taken, mem_halt,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
               id_ex_flush, ex_mem_flush, mem_wb_flush, halted, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait freeze, halt, branch flush,
// load-use bubble, plus a saturating stalled-cycle counter.
module hazard_ctrl (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {RUN, MEMWAIT, HALTED} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_stall_count;

    logic w_mem_busy;
    logic w_load_use;
    logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
    logic w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_flush;
    logic w_halted;

    assign w_mem_busy = hz.mem_req & ~hz.mem_done;
    assign w_load_use = hz.ex_mem_read & hz.ex_reg_write &
                        ((hz.id_uses_rs & (hz.id_rs == hz.ex_write_reg)) |
                         (hz.id_uses_rt & (hz.id_rt == hz.ex_write_reg)));

    always_comb begin
        w_next         = r_state;
        w_pc_en        = 1'b0;
        w_if_id_en     = 1'b0;
        w_id_ex_en     = 1'b0;
        w_ex_mem_en    = 1'b0;
        w_mem_wb_en    = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_mem_wb_flush = 1'b0;
        w_halted       = 1'b0;
        if (rst) begin
            w_next = RUN;
        end else begin
            case (r_state)
                HALTED: begin
                    w_halted = 1'b1;
                end
                default: begin
                    // RUN and MEMWAIT share one priority chain; MEMWAIT only
                    // differs in that it is left once mem_done releases the freeze.
                    w_next = RUN;
                    if (w_mem_busy) begin
                        w_mem_wb_en    = 1'b1;
                        w_mem_wb_flush = 1'b1;
                        w_next         = MEMWAIT;
                    end else if (hz.mem_halt) begin
                        w_mem_wb_en    = 1'b1;
                        w_if_id_flush  = 1'b1;
                        w_id_ex_flush  = 1'b1;
                        w_ex_mem_flush = 1'b1;
                        w_next         = HALTED;
                    end else if (hz.mem_branch_taken) begin
                        w_pc_en        = 1'b1;
                        w_if_id_en     = 1'b1;
                        w_id_ex_en     = 1'b1;
                        w_ex_mem_en    = 1'b1;
                        w_mem_wb_en    = 1'b1;
                        w_if_id_flush  = 1'b1;
                        w_id_ex_flush  = 1'b1;
                        w_ex_mem_flush = 1'b1;
                    end else if (w_load_use) begin
                        w_id_ex_en     = 1'b1;
                        w_id_ex_flush  = 1'b1;
                        w_ex_mem_en    = 1'b1;
                        w_mem_wb_en    = 1'b1;
                    end else begin
                        w_pc_en        = 1'b1;
                        w_if_id_en     = 1'b1;
                        w_id_ex_en     = 1'b1;
                        w_ex_mem_en    = 1'b1;
                        w_mem_wb_en    = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_stall_count <= '0;
        end else begin
            r_state <= w_next;
            // The cycle that enters HALTED is not a stall; the counter saturates.
            if (!w_pc_en && (w_next != HALTED) && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign hz.pc_en        = w_pc_en;
    assign hz.if_id_en     = w_if_id_en;
    assign hz.id_ex_en     = w_id_ex_en;
    assign hz.ex_mem_en    = w_ex_mem_en;
    assign hz.mem_wb_en    = w_mem_wb_en;
    assign hz.if_id_flush  = w_if_id_flush;
    assign hz.id_ex_flush  = w_id_ex_flush;
    assign hz.ex_mem_flush = w_ex_mem_flush;
    assign hz.mem_wb_flush = w_mem_wb_flush;
    assign hz.halted       = w_halted;
    assign hz.stall_count  = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// against a priority-table reference model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    hazard_ctrl_if hz();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: only "halted" and the stall count are observable state.
    bit m_halted = 1'b0;
    int m_count  = 0;

    // {pc, if_id, id_ex, ex_mem, mem_wb, f_if_id, f_id_ex, f_ex_mem, f_mem_wb, halted}
    localparam logic [9:0] V_OFF    = 10'b00000_0000_0;
    localparam logic [9:0] V_HALTED = 10'b00000_0000_1;
    localparam logic [9:0] V_BUSY   = 10'b00001_0001_0;
    localparam logic [9:0] V_HALT   = 10'b00001_1110_0;
    localparam logic [9:0] V_BRANCH = 10'b11111_1110_0;
    localparam logic [9:0] V_LDUSE  = 10'b00111_0100_0;
    localparam logic [9:0] V_RUN    = 10'b11111_0000_0;

    logic [9:0] obs;
    assign obs = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
                  hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.mem_wb_flush,
                  hz.halted};

    function automatic bit is_busy();
        return hz.mem_req && !hz.mem_done;
    endfunction

    function automatic bit is_load_use();
        return hz.ex_mem_read && hz.ex_reg_write &&
               ((hz.id_uses_rs && hz.id_rs == hz.ex_write_reg) ||
                (hz.id_uses_rt && hz.id_rt == hz.ex_write_reg));
    endfunction

    function automatic logic [9:0] model_out();
        if (rst)                  return V_OFF;
        if (m_halted)             return V_HALTED;
        if (is_busy())            return V_BUSY;
        if (hz.mem_halt)          return V_HALT;
        if (hz.mem_branch_taken)  return V_BRANCH;
        if (is_load_use())        return V_LDUSE;
        return V_RUN;
    endfunction

    // Advance one clock and update the model from the inputs held across the edge.
    task automatic tick();
        logic [9:0] e;
        @(posedge clk);
        e = model_out();
        if (rst) begin
            m_halted = 1'b0;
            m_count  = 0;
        end else if (!m_halted) begin
            if (!is_busy() && hz.mem_halt)
                m_halted = 1'b1;
            else if (!e[9] && m_count < 65535)
                m_count = m_count + 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
        hz.ex_mem_read = 1'b0; hz.ex_reg_write = 1'b0; hz.ex_write_reg = '0;
        hz.mem_req = 1'b0; hz.mem_done = 1'b0;
        hz.mem_branch_taken = 1'b0; hz.mem_halt = 1'b0;
    endtask

    task automatic set_load_use();
        idle_inputs();
        hz.ex_mem_read = 1'b1; hz.ex_reg_write = 1'b1; hz.ex_write_reg = 3'd3;
        hz.id_rs = 3'd3; hz.id_uses_rs = 1'b1;
    endtask

    task automatic random_inputs();
        hz.id_rs            = 3'($urandom_range(0, 7));
        hz.id_rt            = 3'($urandom_range(0, 7));
        hz.id_uses_rs       = 1'($urandom_range(0, 1));
        hz.id_uses_rt       = 1'($urandom_range(0, 1));
        hz.ex_mem_read      = 1'($urandom_range(0, 1));
        hz.ex_reg_write     = 1'($urandom_range(0, 1));
        hz.ex_write_reg     = 3'($urandom_range(0, 3));
        hz.mem_req          = 1'($urandom_range(0, 1));
        hz.mem_done         = 1'($urandom_range(0, 1));
        hz.mem_branch_taken = ($urandom_range(0, 3) == 0);
        hz.mem_halt         = ($urandom_range(0, 19) == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        random_inputs();
        hz.mem_halt = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs !== V_OFF) $display("FAIL reset_outputs: got %b expected %b", obs, V_OFF);
        else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_total++;
        if (hz.stall_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", hz.stall_count);
        else n_pass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (obs !== V_RUN) $display("FAIL reset_release: got %b expected %b", obs, V_RUN);
        else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        @(negedge clk);
        n_total++;
        if (obs !== V_LDUSE) $display("FAIL load_use_rs: got %b expected %b", obs, V_LDUSE);
        else n_pass++;
        tick();
        n_total++;
        if (hz.stall_count !== 16'd1) $display("FAIL load_use_count: got %0d expected 1", hz.stall_count);
        else n_pass++;
        idle_inputs();
        @(negedge clk);
        n_total++;
        if (obs !== V_RUN) $display("FAIL load_use_release: got %b expected %b", obs, V_RUN);
        else n_pass++;
        // rt match counts only when the instruction actually reads rt
        set_load_use();
        hz.id_uses_rs = 1'b0; hz.id_rt = 3'd3; hz.id_uses_rt = 1'b0;
        @(negedge clk);
        n_total++;
        if (obs !== V_RUN) $display("FAIL load_use_rt_unused: got %b expected %b", obs, V_RUN);
        else n_pass++;
        hz.id_uses_rt = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs !== V_LDUSE) $display("FAIL load_use_rt: got %b expected %b", obs, V_LDUSE);
        else n_pass++;
        hz.ex_mem_read = 1'b0;
        @(negedge clk);
        n_total++;
        if (obs !== V_RUN) $display("FAIL no_load_alu_result: got %b expected %b", obs, V_RUN);
        else n_pass++;
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        hz.mem_req = 1'b1; hz.mem_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if (obs !== V_BUSY) $display("FAIL mem_wait_cycle%0d: got %b expected %b", i, obs, V_BUSY);
            else n_pass++;
            tick();
        end
        hz.mem_done = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs !== V_RUN) $display("FAIL mem_wait_release: got %b expected %b", obs, V_RUN);
        else n_pass++;
        tick();
        n_total++;
        if (hz.stall_count !== 16'd4) $display("FAIL mem_wait_count: got %0d expected 4", hz.stall_count);
        else n_pass++;
    endtask

    task automatic test_branch_load_use();
        do_reset();
        set_load_use();
        hz.mem_branch_taken = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs !== V_BRANCH) $display("FAIL branch_over_load_use: got %b expected %b", obs, V_BRANCH);
        else n_pass++;
        tick();
        n_total++;
        if (hz.stall_count !== 16'd0) $display("FAIL branch_count: got %0d expected 0", hz.stall_count);
        else n_pass++;
    endtask

    task automatic test_halt_busy();
        do_reset();
        hz.mem_halt = 1'b1; hz.mem_req = 1'b1; hz.mem_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_total++;
            if (obs !== V_BUSY) $display("FAIL halt_busy_cycle%0d: got %b expected %b", i, obs, V_BUSY);
            else n_pass++;
            tick();
        end
        hz.mem_done = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs !== V_HALT) $display("FAIL halt_entry: got %b expected %b", obs, V_HALT);
        else n_pass++;
        tick();
        for (int i = 0; i < 12; i++) begin
            random_inputs();
            @(negedge clk);
            n_total++;
            if (obs !== V_HALTED) $display("FAIL halted_hold%0d: got %b expected %b", i, obs, V_HALTED);
            else n_pass++;
            tick();
        end
        n_total++;
        if (hz.stall_count !== 16'd2) $display("FAIL halted_count: got %0d expected 2", hz.stall_count);
        else n_pass++;
    endtask

    task automatic test_reset_from_halted();
        do_reset();
        set_load_use();
        repeat (5) tick();
        idle_inputs();
        hz.mem_halt = 1'b1;
        tick();
        idle_inputs();
        @(negedge clk);
        n_total++;
        if (obs !== V_HALTED || hz.stall_count !== 16'd5)
            $display("FAIL halted_before_reset: got %b/%0d expected %b/5", obs, hz.stall_count, V_HALTED);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs !== V_OFF) $display("FAIL halted_reset_outputs: got %b expected %b", obs, V_OFF);
        else n_pass++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (obs !== V_RUN || hz.stall_count !== 16'd0)
            $display("FAIL halted_reset_release: got %b/%0d expected %b/0", obs, hz.stall_count, V_RUN);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            rst = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            n_total++;
            if (obs !== model_out())
                $display("FAIL random_outputs@%0d: got %b expected %b", i, obs, model_out());
            else n_pass++;
            n_total++;
            if (hz.stall_count !== 16'(m_count))
                $display("FAIL random_count@%0d: got %0d expected %0d", i, hz.stall_count, m_count);
            else n_pass++;
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        set_load_use();
        repeat (65534) tick();
        @(negedge clk);
        n_total++;
        if (hz.stall_count !== 16'hFFFE) $display("FAIL sat_before: got %h expected fffe", hz.stall_count);
        else n_pass++;
        repeat (6) tick();
        @(negedge clk);
        n_total++;
        if (hz.stall_count !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", hz.stall_count);
        else n_pass++;
        n_total++;
        if (obs !== V_LDUSE) $display("FAIL sat_outputs: got %b expected %b", obs, V_LDUSE);
        else n_pass++;
        tick();
        n_total++;
        if (hz.stall_count !== 16'hFFFF) $display("FAIL sat_no_wrap: got %h expected ffff", hz.stall_count);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch_load_use();
        test_halt_busy();
        test_reset_from_halted();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
